// File: rtl/key_schedule_ctrl_if.sv
// Key-load handshake and round-key read bus between the cipher datapath
// (master) and the key-schedule controller (slave).
interface key_schedule_ctrl_if;
    logic         key_valid;
    logic         key_ready;
    logic [0:127] key_in;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic [0:127] rk_out;
    logic         rk_valid;
    logic         busy;
    logic         done;

    modport master (
        output key_valid, key_in, rk_req, rk_idx,
        input  key_ready, rk_out, rk_valid, busy, done
    );

    modport slave (
        input  key_valid, key_in, rk_req, rk_idx,
        output key_ready, rk_out, rk_valid, busy, done
    );
endinterface

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key-schedule controller.
// A cipher key is accepted over a valid/ready handshake, then expanded
// through a single shared RotWord/SubWord/Rcon path into 44 words kept in
// four word banks (bank j holds word 4r+j of round r).
// Round keys are served with one cycle of read latency.
// Optional build macro KS_FAST_EN: expand a whole round key (4 words) per
// cycle instead of one word per cycle; still one SubWord instance.
module key_schedule_ctrl #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    key_schedule_ctrl_if.slave ks
);
    localparam int         NW       = NK * (NR + 1);
    localparam logic [5:0] LAST_CNT = 6'(NW - 1);
`ifdef KS_FAST_EN
    // cnt holds the index of the first word of the round being written
    localparam logic [5:0] FINAL_CNT = LAST_CNT - 6'd3;
    localparam logic [5:0] CNT_STEP  = 6'd4;
`else
    localparam logic [5:0] FINAL_CNT = LAST_CNT;
    localparam logic [5:0] CNT_STEP  = 6'd1;
`endif

    // FIPS-197 S-box, byte x lives at bits [8x +: 8] (bit 0 is the MSB)
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t            state_reg;
    logic [5:0]        cnt_reg;
    logic [7:0]        rcon_reg;
    logic [3:0][31:0]  win_reg;       // w[cnt-4] .. w[cnt-1], index 0 oldest
    logic              key_ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              rk_valid_reg;

    logic [31:0]       key_word [4];
    logic [31:0]       rk_word  [4];
    logic [31:0]       sub_in;
    logic [31:0]       sub_out;
    logic [31:0]       g_word;
    logic [3:0][31:0]  win_next;
    logic [3:0]        wr_en;
    logic [3:0]        wr_addr;
    logic [3:0][31:0]  wr_data;
    logic              accept;
    logic              rd_en;
    logic              rd_oob;

    assign accept = ks.key_valid && key_ready_reg;
    assign rd_en  = ks.rk_req && (state_reg == READY);
    assign rd_oob = ks.rk_idx > 4'(NR);

    // RotWord on the newest word feeds the single shared SubWord instance
    assign sub_in = {win_reg[3][23:0], win_reg[3][31:24]};
    assign g_word = sub_out ^ {rcon_reg, 24'h0};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word_lane
            // key word gi, MSB-first ordering carried over from key_in
            assign key_word[gi] = ks.key_in[32*gi +: 32];
            assign sub_out[8*gi +: 8] = sbox(sub_in[8*gi +: 8]);
        end
    endgenerate

    // Next contents of the sliding window (newly produced words)
    always_comb begin
        win_next = win_reg;
`ifdef KS_FAST_EN
        win_next[0] = g_word ^ win_reg[0];
        win_next[1] = win_reg[1] ^ win_next[0];
        win_next[2] = win_reg[2] ^ win_next[1];
        win_next[3] = win_reg[3] ^ win_next[2];
`else
        win_next[0] = win_reg[1];
        win_next[1] = win_reg[2];
        win_next[2] = win_reg[3];
        win_next[3] = (cnt_reg[1:0] == 2'b00) ? (g_word ^ win_reg[0])
                                              : (win_reg[0] ^ win_reg[3]);
`endif
    end

    // Bank write steering: key load fills round 0, expansion fills the rest
    always_comb begin
        wr_en   = 4'b0000;
        wr_addr = cnt_reg[5:2];
`ifdef KS_FAST_EN
        wr_data = win_next;
`else
        wr_data = {win_next[3], win_next[3], win_next[3], win_next[3]};
`endif
        if (accept) begin
            wr_en   = 4'b1111;
            wr_addr = 4'd0;
            wr_data = {key_word[3], key_word[2], key_word[1], key_word[0]};
        end else if (state_reg == EXPAND) begin
`ifdef KS_FAST_EN
            wr_en = 4'b1111;
`else
            wr_en[cnt_reg[1:0]] = 1'b1;
`endif
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [31:0] bank_mem [0:NR];
            logic [31:0] rd_word_reg;

            // Word storage is never cleared; only written
            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    bank_mem[wr_addr] <= wr_data[gi];
                end
            end

            // Registered read; holds its value when no READY-state request
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_word_reg <= 32'h0;
                end else if (rd_en) begin
                    rd_word_reg <= rd_oob ? 32'h0 : bank_mem[ks.rk_idx];
                end
            end

            assign rk_word[gi] = rd_word_reg;
        end
    endgenerate

    // Control FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 6'd0;
            rcon_reg      <= 8'h01;
            win_reg       <= '0;
            key_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rk_valid_reg  <= 1'b0;
        end else begin
            rk_valid_reg <= rd_en;
            case (state_reg)
                IDLE, READY: begin
                    if (accept) begin
                        state_reg     <= EXPAND;
                        win_reg       <= {key_word[3], key_word[2], key_word[1], key_word[0]};
                        cnt_reg       <= 6'd4;
                        rcon_reg      <= 8'h01;
                        key_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                    end
                end
                EXPAND: begin
                    win_reg <= win_next;
`ifdef KS_FAST_EN
                    rcon_reg <= xtime(rcon_reg);
`else
                    if (cnt_reg[1:0] == 2'b00) begin
                        rcon_reg <= xtime(rcon_reg);
                    end
`endif
                    if (cnt_reg == FINAL_CNT) begin
                        state_reg     <= READY;
                        key_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_STEP;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ks.key_ready = key_ready_reg;
    assign ks.busy      = busy_reg;
    assign ks.done      = done_reg;
    assign ks.rk_valid  = rk_valid_reg;
    assign ks.rk_out    = {rk_word[0], rk_word[1], rk_word[2], rk_word[3]};
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using FIPS-197 reference vectors.
module tb_key_schedule_ctrl;
`ifdef KS_FAST_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 40;
`endif
    localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KX      = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cyc;

    key_schedule_ctrl_if ksif ();

    key_schedule_ctrl #(.NR(10), .NK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ksif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until done rises; optionally confirm reads are refused
    task automatic wait_done(input string tag, input bit chk_rv, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (chk_rv) chk({tag, "_rv"}, 128'(ksif.rk_valid), 128'd0);
            if (ksif.done) break;
        end
        chk({tag, "_lat"}, 128'(n), 128'(LAT));
    endtask

    task automatic read(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        ksif.rk_req = 1'b1;
        ksif.rk_idx = idx;
        tick();
        chk({tag, "_v"}, 128'(ksif.rk_valid), 128'd1);
        chk(tag, ksif.rk_out, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_kr"}, 128'(ksif.key_ready), 128'd1);
        chk({tag, "_busy"}, 128'(ksif.busy), 128'd0);
        chk({tag, "_done"}, 128'(ksif.done), 128'd0);
        chk({tag, "_rv"}, 128'(ksif.rk_valid), 128'd0);
        chk({tag, "_rk"}, ksif.rk_out, 128'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        ksif.key_valid = 1'b0;
        ksif.key_in    = '0;
        ksif.rk_req    = 1'b0;
        ksif.rk_idx    = 4'd0;
        tick();
        tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // First key; a different key stays offered throughout EXPAND
        ksif.key_valid = 1'b1;
        ksif.key_in    = K1;
        tick();
        chk("t0_busy", 128'(ksif.busy), 128'd1);
        chk("t0_kr", 128'(ksif.key_ready), 128'd0);
        ksif.key_in = KX;
        ksif.rk_req = 1'b1;
        ksif.rk_idx = 4'd0;
        wait_done("k1", 1'b1, cyc);
        ksif.key_valid = 1'b0;
        chk("k1_busy", 128'(ksif.busy), 128'd0);

        read("k1_rk0", 4'd0, K1);
        read("k1_rk1", 4'd1, K1_RK1);
        read("k1_rk12", 4'd12, 128'd0);
        read("k1_rk10", 4'd10, K1_RK10);
        ksif.rk_req = 1'b0;
        tick();
        chk("idle_rv", 128'(ksif.rk_valid), 128'd0);
        chk("idle_hold", ksif.rk_out, K1_RK10);

        // New all-zero key accepted together with a read of index 10
        ksif.rk_req    = 1'b1;
        ksif.rk_idx    = 4'd10;
        ksif.key_valid = 1'b1;
        ksif.key_in    = '0;
        tick();
        ksif.key_valid = 1'b0;
        ksif.rk_req    = 1'b0;
        chk("ovl_rv", 128'(ksif.rk_valid), 128'd1);
        chk("ovl_rk", ksif.rk_out, K1_RK10);
        chk("ovl_done", 128'(ksif.done), 128'd0);
        wait_done("z", 1'b0, cyc);
        read("z_rk1", 4'd1, Z_RK1);
        read("z_rk0", 4'd0, 128'd0);
        read("z_rk10", 4'd10, Z_RK10);
        ksif.rk_req = 1'b0;

        // Reset pulsed 20 cycles into an expansion
        ksif.key_valid = 1'b1;
        ksif.key_in    = K1;
        tick();
        ksif.key_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_busy", 128'(ksif.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        #2;
        rst_n = 1'b1;
        tick();
        ksif.key_valid = 1'b1;
        ksif.key_in    = K1;
        tick();
        ksif.key_valid = 1'b0;
        wait_done("rerun", 1'b0, cyc);
        read("rr_rk10", 4'd10, K1_RK10);
        read("rr_rk1", 4'd1, K1_RK1);
        ksif.rk_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
